// File: rtl/instr_decoder_pipe.sv
// RV32I instruction decoder feeding a registered main + skid output buffer with retired-entry counters.
// Optional macro RV32M_EN: accepts R-type funct7=0000001 words as legal and flags them on o_muldiv.
module instr_decoder_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [XLEN-1:0]  i_pc,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_pc,
  output logic [6:0]       o_opcode,
  output logic [2:0]       o_funct3,
  output logic [4:0]       o_rd,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [XLEN-1:0]  o_imm,
  output logic             o_illegal,
  output logic             o_muldiv,
  output logic [CNT_W-1:0] o_cnt_decoded,
  output logic [CNT_W-1:0] o_cnt_illegal
);

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            muldiv;
  } entry_t;

`ifdef RV32M_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  entry_t            dec;
  logic signed [31:0] imm32;
  logic [2:0]        f3;
  logic [6:0]        f7;

  entry_t            main_q, main_d, skid_q, skid_d;
  logic              main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  cnt_dec_q, cnt_dec_d, cnt_ill_q, cnt_ill_d;
  logic              in_hs, out_hs;

  assign f3 = i_instr[14:12];
  assign f7 = i_instr[31:25];

  // All nine base opcodes end in 2'b11, so compressed-quadrant words land in the default arm.
  always_comb begin
    dec        = '0;
    imm32      = '0;
    dec.pc     = i_pc;
    dec.opcode = i_instr[6:0];
    dec.funct3 = f3;
    dec.rd     = i_instr[11:7];
    dec.rs1    = i_instr[19:15];
    dec.rs2    = i_instr[24:20];
    case (i_instr[6:0])
      OP_LUI, OP_AUIPC: imm32 = {i_instr[31:12], 12'b0};
      OP_JAL: imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      OP_JALR: begin
        imm32       = {{20{i_instr[31]}}, i_instr[31:20]};
        dec.illegal = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        imm32       = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
        dec.illegal = (f3[2:1] == 2'b01);
        dec.rd      = '0;
      end
      OP_LOAD: begin
        imm32       = {{20{i_instr[31]}}, i_instr[31:20]};
        dec.illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OP_STORE: begin
        imm32       = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
        dec.illegal = (f3 > 3'b010);
        dec.rd      = '0;
      end
      OP_IMM: begin
        imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
        if (f3 == 3'b001)
          dec.illegal = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          dec.illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
      end
      OP_REG: begin
        dec.muldiv  = MEXT && (f7 == 7'b0000001);
        dec.illegal = !((f7 == 7'b0000000) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                        dec.muldiv);
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.imm = XLEN'(imm32);
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign in_hs  = i_valid & ready_q;
  assign out_hs = main_vld_q & i_ready;

  // Skid only fills while main is held; on drain it refills main first to keep order.
  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    cnt_dec_d  = cnt_dec_q;
    cnt_ill_d  = cnt_ill_q;
    if (i_flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_hs) begin
      cnt_dec_d = sat_inc(cnt_dec_q);
      if (main_q.illegal)
        cnt_ill_d = sat_inc(cnt_ill_q);
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (in_hs) begin
        main_d = dec;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_hs) begin
      if (main_vld_q) begin
        skid_d     = dec;
        skid_vld_d = 1'b1;
      end else begin
        main_d     = dec;
        main_vld_d = 1'b1;
      end
    end
    ready_d = ~skid_vld_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      cnt_dec_q  <= '0;
      cnt_ill_q  <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      ready_q    <= ready_d;
      cnt_dec_q  <= cnt_dec_d;
      cnt_ill_q  <= cnt_ill_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_valid       = main_vld_q;
  assign o_pc          = main_q.pc;
  assign o_opcode      = main_q.opcode;
  assign o_funct3      = main_q.funct3;
  assign o_rd          = main_q.rd;
  assign o_rs1         = main_q.rs1;
  assign o_rs2         = main_q.rs2;
  assign o_imm         = main_q.imm;
  assign o_illegal     = main_q.illegal;
  assign o_muldiv      = main_q.muldiv;
  assign o_cnt_decoded = cnt_dec_q;
  assign o_cnt_illegal = cnt_ill_q;

endmodule

// File: doc/instr_decoder_pipe.md
INSTR_DECODER_PIPE -- requirements
Module: instr_decoder_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width of PC and immediate (32 or 64).
REQ-002 SHALL have parameter CNT_W, default 16, width of statistic counters.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port i_flush  input  1  discard all buffered entries.
REQ-006 SHALL have port i_valid  input  1  upstream instruction valid.
REQ-007 SHALL have port o_ready  output  1  decoder can accept.
REQ-008 SHALL have port i_instr  input  32  raw instruction word.
REQ-009 SHALL have port i_pc  input  XLEN  instruction address.
REQ-010 SHALL have port o_valid  output  1  decoded entry valid.
REQ-011 SHALL have port i_ready  input  1  downstream accepts.
REQ-012 SHALL have ports o_pc XLEN, o_opcode 7, o_funct3 3, o_rd 5, o_rs1 5, o_rs2 5 (all outputs), carrying the decoded fields.
REQ-013 SHALL have port o_imm  output  XLEN  sign-extended immediate.
REQ-014 SHALL have ports o_illegal 1 and o_muldiv 1 (outputs): illegal-instruction flag and M-extension flag.
REQ-015 SHALL have ports o_cnt_decoded and o_cnt_illegal  output  CNT_W  retired-entry counts.

Function
REQ-016 SHALL register outputs: 1-cycle latency from input handshake (i_valid & o_ready) to o_valid.
REQ-017 SHALL contain a main output register plus one skid register; o_ready is registered and equals "skid empty".
REQ-018 SHALL hold all o_* fields stable while o_valid=1 and i_ready=0.
REQ-019 On output handshake with skid full, skid entry SHALL move to main register in the same cycle; order SHALL be preserved.
REQ-020 Simultaneous input and output handshake with skid empty SHALL load the new entry directly into main register (full throughput, no bubble).
REQ-021 Immediate SHALL follow format: I (Load, I_type, JALR), S (Store), B (B_type, bit0=0), U (LUI, AUIPC, low 12 bits 0), J (JAL, bit0=0); R_type imm = 0; sign bit instr[31] extended to XLEN.
REQ-022 o_illegal SHALL be 1 when instr[1:0]!=2'b11, opcode is not one of the nine RV32I base opcodes, JALR funct3!=000, B_type funct3 010/011, Load funct3 011/110/111, Store funct3 >=011, SLLI funct7!=0, SRLI/SRAI funct7 not 0000000/0100000, or R_type funct7 not a legal base/M encoding.
REQ-023 Illegal entries SHALL still pass through the buffer with fields decoded raw; downstream decides trap.
REQ-024 On each output handshake o_cnt_decoded SHALL increment; o_cnt_illegal SHALL additionally increment if o_illegal=1; both saturate at all-ones.
REQ-025 i_flush SHALL clear main and skid valid bits next cycle; an input handshake coinciding with i_flush SHALL be discarded; counters SHALL not change on flush.
REQ-026 o_rd SHALL be forced to 0 for B_type and Store.

Reset
REQ-027 On i_reset=1 at a rising edge: o_valid=0, skid empty, o_ready=1, counters=0, all data outputs=0.
REQ-028 Reset mid-transfer SHALL drop buffered entries; reset SHALL take priority over i_flush and handshakes.

Configuration
REQ-029 Macro RV32M_EN: when defined, R_type with funct7=0000001 (any funct3) SHALL be legal with o_muldiv=1; when undefined, such words SHALL set o_illegal=1 and o_muldiv SHALL be tied 0.

Verification
REQ-030 Reset, then i_instr=32'h00500093 (ADDI x1,x0,5), i_ready=1 -> next cycle o_valid=1, o_rd=1, o_imm=5, o_illegal=0.
REQ-031 i_instr=32'hFE000EE3 (BEQ x0,x0,-4) -> o_imm=-4 sign-extended, o_rd=0, o_opcode=7'b1100011.
REQ-032 i_ready=0, three back-to-back inputs -> first two held (main+skid), o_ready=0 after second, third stalls; release i_ready -> order 1,2,3 preserved, no loss.
REQ-033 i_instr=32'h02208033 (MUL) -> with RV32M_EN o_muldiv=1, o_illegal=0; without it o_illegal=1, o_cnt_illegal increments.
REQ-034 i_instr=32'h0000007F and 32'h00001067 (JALR funct3=001) -> o_illegal=1 each, o_cnt_illegal=2, o_cnt_decoded=2.
REQ-035 Buffer full, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ready=1, counters unchanged.
